// File: rtl/hazard_control_vp.sv
// rtl/hazard_control_vp.sv - pipeline hazard, flush and memory-wait control
//
// Ports:
//   clock, async_reset        : clock, asynchronous active-low reset
//   r1_D, r2_D                : decode-stage source register indices
//   rd_E                      : execute-stage destination index
//   result_source_E           : execute result select (2'b01 = load)
//   write_scalar_reg_E,
//   write_vector_reg_E        : execute-stage register write enables
//   branch_taken_E            : taken branch/jump resolved in execute
//   mem_request_M, mem_ready  : memory-stage handshake
//   enable_F/D, enabler_E,
//   enable_M                  : pipe register / PC enables
//   sync_reset_D/E            : synchronous flush of D and E registers
//   mem_timeout               : sticky memory-wait timeout flag
//   stall_cycles              : saturating count of stalled cycles
module hazard_control_vp #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              async_reset,
    input  logic [ADDR_W-1:0] r1_D,
    input  logic [ADDR_W-1:0] r2_D,
    input  logic [ADDR_W-1:0] rd_E,
    input  logic [1:0]        result_source_E,
    input  logic              write_scalar_reg_E,
    input  logic              write_vector_reg_E,
    input  logic              branch_taken_E,
    input  logic              mem_request_M,
    input  logic              mem_ready,
    output logic              enable_F,
    output logic              enable_D,
    output logic              enabler_E,
    output logic              enable_M,
    output logic              sync_reset_D,
    output logic              sync_reset_E,
    output logic              mem_timeout,
    output logic [15:0]       stall_cycles
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       hazard;
    logic       freeze;

    // Load-use hazard: only index 0 (scalar x0) is hard-wired; vector
    // index 32 is a real register and compares like any other.
    always_comb begin
        hazard = (result_source_E == 2'b01)
               && (write_scalar_reg_E || write_vector_reg_E)
               && (rd_E != '0)
               && ((rd_E == r1_D) || (rd_E == r2_D));
    end

    always_comb begin
        freeze = 1'b0;
        if (state == RUN) begin
            freeze = mem_request_M && !mem_ready;
        end else begin
            freeze = !mem_ready;
        end
    end

    // Priority: reset > memory freeze > branch flush > load-use bubble.
    always_comb begin
        enable_F     = 1'b1;
        enable_D     = 1'b1;
        enabler_E    = 1'b1;
        enable_M     = 1'b1;
        sync_reset_D = 1'b0;
        sync_reset_E = 1'b0;
        if (!async_reset) begin
            enable_F     = 1'b0;
            enable_D     = 1'b0;
            enabler_E    = 1'b0;
            enable_M     = 1'b0;
            sync_reset_D = 1'b1;
            sync_reset_E = 1'b1;
        end else if (freeze) begin
            enable_F  = 1'b0;
            enable_D  = 1'b0;
            enabler_E = 1'b0;
            enable_M  = 1'b0;
        end else if (branch_taken_E) begin
            sync_reset_D = 1'b1;
            sync_reset_E = 1'b1;
        end else if (hazard) begin
            enable_F     = 1'b0;
            enable_D     = 1'b0;
            sync_reset_E = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (mem_request_M && !mem_ready) state_nxt = MEM_WAIT;
            MEM_WAIT: if (mem_ready) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            state        <= RUN;
            wait_cnt     <= 8'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= 16'd0;
        end else begin
            state <= state_nxt;

            if (state == RUN) begin
                wait_cnt <= (state_nxt == MEM_WAIT) ? 8'd1 : 8'd0;
            end else if (mem_ready) begin
                wait_cnt <= 8'd0;
            end else if (wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if ((state == MEM_WAIT) && (wait_cnt == TIMEOUT_CNT)) begin
                mem_timeout <= 1'b1;
            end

            if ((freeze || hazard) && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_control_vp.sv
// tb/tb_hazard_control_vp.sv - self-checking bench for hazard_control_vp
module tb_hazard_control_vp;

    localparam int AW = 6;
    localparam int TO = 255;

    logic          clock = 1'b0;
    logic          async_reset = 1'b0;
    logic [AW-1:0] r1_D = '0, r2_D = '0, rd_E = '0;
    logic [1:0]    result_source_E = 2'b00;
    logic          write_scalar_reg_E = 1'b0, write_vector_reg_E = 1'b0;
    logic          branch_taken_E = 1'b0, mem_request_M = 1'b0, mem_ready = 1'b0;
    logic          enable_F, enable_D, enabler_E, enable_M;
    logic          sync_reset_D, sync_reset_E, mem_timeout;
    logic [15:0]   stall_cycles;

    hazard_control_vp #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clock              (clock),
        .async_reset        (async_reset),
        .r1_D               (r1_D),
        .r2_D               (r2_D),
        .rd_E               (rd_E),
        .result_source_E    (result_source_E),
        .write_scalar_reg_E (write_scalar_reg_E),
        .write_vector_reg_E (write_vector_reg_E),
        .branch_taken_E     (branch_taken_E),
        .mem_request_M      (mem_request_M),
        .mem_ready          (mem_ready),
        .enable_F           (enable_F),
        .enable_D           (enable_D),
        .enabler_E          (enabler_E),
        .enable_M           (enable_M),
        .sync_reset_D       (sync_reset_D),
        .sync_reset_E       (sync_reset_E),
        .mem_timeout        (mem_timeout),
        .stall_cycles       (stall_cycles)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: "waiting" flag, cycles spent waiting, sticky flag, count.
    bit m_wait = 0;
    int m_waited = 0;
    bit m_to = 0;
    int m_stall = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hazard();
        int rd = int'(rd_E);
        return result_source_E == 2'b01 && (write_scalar_reg_E || write_vector_reg_E)
            && rd != 0 && (rd == int'(r1_D) || rd == int'(r2_D));
    endfunction

    function automatic bit m_freeze();
        return m_wait ? !mem_ready : (mem_request_M && !mem_ready);
    endfunction

    task automatic check_outputs(input string tag);
        logic [5:0] exp;
        if (!async_reset)             exp = 6'b0000_11;
        else if (m_freeze())          exp = 6'b0000_00;
        else if (branch_taken_E)      exp = 6'b1111_11;
        else if (m_hazard())          exp = 6'b0011_01;
        else                          exp = 6'b1111_00;
        chk({tag, ".ctl"}, 16'({enable_F, enable_D, enabler_E, enable_M, sync_reset_D, sync_reset_E}),
            16'(exp));
        chk({tag, ".timeout"}, 16'(mem_timeout), 16'(m_to));
        chk({tag, ".stalls"}, stall_cycles, 16'(m_stall));
    endtask

    task automatic model_reset();
        m_wait = 0; m_waited = 0; m_to = 0; m_stall = 0;
    endtask

    task automatic model_edge();
        bit f, h;
        if (!async_reset) begin
            model_reset();
            return;
        end
        f = m_freeze();
        h = m_hazard();
        if (f || h) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        if (m_wait) begin
            if (m_waited == TO) m_to = 1;
            if (mem_ready) m_wait = 0;
            else m_waited = (m_waited < 255) ? m_waited + 1 : 255;
        end else if (mem_request_M && !mem_ready) begin
            m_wait = 1;
            m_waited = 1;
        end
    endtask

    task automatic tick(input string tag);
        @(negedge clock);
        check_outputs(tag);
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic [1:0] rs, input logic ws, input logic wv,
                          input int rd, input int r1, input int r2,
                          input logic br, input logic req, input logic rdy);
        result_source_E = rs; write_scalar_reg_E = ws; write_vector_reg_E = wv;
        rd_E = AW'(rd); r1_D = AW'(r1); r2_D = AW'(r2);
        branch_taken_E = br; mem_request_M = req; mem_ready = rdy;
    endtask

    function automatic int pick_idx();
        case ($urandom_range(0, 4))
            0: return 0;
            1: return 5;
            2: return 32;
            3: return 33;
            default: return int'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        // Reset state
        set_in(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("reset0");
        tick("reset1");
        async_reset = 1'b1;
        tick("idle");

        // Load-use bubble lasts exactly one cycle
        set_in(2'b01, 1, 0, 5, 1, 5, 0, 0, 0);
        tick("loaduse");
        set_in(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("loaduse_after");
        chk("loaduse_count", stall_cycles, 16'd1);

        // x0 never stalls
        set_in(2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
        tick("x0load");

        // Vector index 33 bubble
        set_in(2'b01, 0, 1, 33, 33, 2, 0, 0, 0);
        tick("vecload");
        set_in(2'b01, 0, 1, 32, 32, 32, 0, 0, 0);
        tick("vec0load");
        set_in(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("vec_after");

        // Branch overrides hazard
        set_in(2'b01, 1, 0, 5, 5, 5, 1, 0, 0);
        tick("branch_haz");

        // Four frozen cycles, released in the mem_ready cycle
        set_in(2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
        model_reset();
        async_reset = 1'b0; #1; async_reset = 1'b1;
        for (int i = 0; i < 4; i++) tick("memwait");
        mem_ready = 1'b1;
        tick("memready");
        set_in(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("mem_done");
        chk("memwait_count", stall_cycles, 16'd4);

        // Long wait: timeout sets, then async reset aborts mid-wait
        set_in(2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 300; i++) tick("longwait");
        chk("timeout_set", 16'(mem_timeout), 16'd1);
        #2;
        async_reset = 1'b0;
        #1;
        model_reset();
        chk("async_ctl", 16'({enable_F, enable_D, enabler_E, enable_M, sync_reset_D, sync_reset_E}),
            16'h03);
        chk("async_timeout", 16'(mem_timeout), 16'd0);
        chk("async_stalls", stall_cycles, 16'd0);
        tick("in_reset");
        async_reset = 1'b1;
        set_in(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("post_reset");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            set_in(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   pick_idx(), pick_idx(), pick_idx(),
                   1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 199) == 0) async_reset = 1'b0;
            else async_reset = 1'b1;
            if (!async_reset) begin
                #1;
                model_reset();
            end
            tick("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
